poly_from_roots: RTL and testbench

- Builds the monic polynomial Q(X) = prod_{k=0..W-1} (X - r_k) over the byte field (GF256 or P251) from W roots held in a byte memory.
- Writes the coefficients q_0..q_{W-1} into the Q coefficient memory. The leading 1 is implicit and never stored.
- It is the writer side of the Q memory that the evaluate block later reads through o_q_addr/i_q. Same memory layout, same single-port, 1-cycle-latency mem_single.

---
 rtl/poly_from_roots_pkg.sv | 30 +++
 rtl/poly_from_roots_byte_mul_sub.sv | 38 +++
 rtl/poly_from_roots.sv | 147 ++++++++++++++
 tb/tb_poly_from_roots.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/poly_from_roots_pkg.sv
// Shared constants and FSM encoding for poly_from_roots.
// POLY_SHARED_MUL_EN adds the multiplier-wait state used with an external GF(2^8) multiplier.
package poly_from_roots_pkg;

    localparam int unsigned P251_MOD   = 251;
    localparam int unsigned W_L1       = 79;
    localparam int unsigned W_L3       = 120;
    localparam int unsigned W_L5       = 150;
    localparam logic [8:0]  GF256_POLY = 9'h11B;

    typedef enum logic [3:0] {
        S_IDLE,
        S_R_RD,
        S_R_LAT,
        S_C_RD,
        S_C_MUL,
        S_C_WR,
        S_C_TOP,
        S_DONE
`ifdef POLY_SHARED_MUL_EN
        , S_C_MWAIT
`endif
    } state_t;

    // Multiply by X modulo the AES polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF256_POLY[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/poly_from_roots_byte_mul_sub.sv
// Combinational field multiply-subtract o_y = i_a - i_b*i_c over GF256 or integers mod 251.
module byte_mul_sub
    import poly_from_roots_pkg::*;
#(
    parameter string FIELD = "P251"
) (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_c,
    output logic [7:0] o_y
);

    generate
        if (FIELD == "GF256") begin : g_gf256
            logic [7:0] w_prod;
            logic [7:0] w_sh;

            always_comb begin
                w_prod = '0;
                w_sh   = i_b;
                for (int unsigned i = 0; i < 8; i++) begin
                    if (i_c[i]) w_prod = w_prod ^ w_sh;
                    w_sh = gf_xtime(w_sh);
                end
            end

            assign o_y = i_a ^ w_prod;
        end else begin : g_p251
            logic [7:0] w_prod;

            assign w_prod = 8'((16'(i_b) * 16'(i_c)) % 16'(P251_MOD));
            // Both operands are already reduced, so one conditional add of the modulus suffices.
            assign o_y = (i_a >= w_prod) ? (i_a - w_prod)
                                         : 8'(9'(i_a) + 9'(P251_MOD) - 9'(w_prod));
        end
    endgenerate

endmodule

// File: rtl/poly_from_roots.sv
// Builds monic Q(X) = prod (X - r_k) in place in the Q memory from W roots.
// Define POLY_SHARED_MUL_EN to use an external shared GF(2^8) multiplier for the C_WR product.
module poly_from_roots
    import poly_from_roots_pkg::*;
#(
    parameter string       FIELD         = "P251",
    parameter string       PARAMETER_SET = "L5",
    parameter int unsigned W             = (PARAMETER_SET == "L1") ? W_L1 :
                                           (PARAMETER_SET == "L3") ? W_L3 : W_L5,
    parameter int unsigned AW            = $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic [AW-1:0] o_root_addr,
    input  logic [7:0]    i_root,
    output logic [AW-1:0] o_q_addr,
    output logic          o_q_wr_en,
    output logic [7:0]    o_q_data,
    input  logic [7:0]    i_q,
`ifdef POLY_SHARED_MUL_EN
    output logic          o_start_mul_gf8,
    output logic [7:0]    o_in_1_mul_gf8,
    output logic [7:0]    o_in_2_mul_gf8,
    input  logic [7:0]    i_out_mul_gf8,
    input  logic          i_done_mul_gf8,
`endif
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [AW-1:0] K_LAST = AW'(W - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_j;
    logic [7:0]    r_r;
    logic [7:0]    r_prev;
    logic [7:0]    r_old;
    logic [7:0]    w_b;
    logic [7:0]    w_c;
    logic [7:0]    w_ms;

`ifdef POLY_SHARED_MUL_EN
    logic [7:0]    r_prod;

    // Product arrives pre-computed, so the local unit only subtracts (c = 1).
    assign w_b = (r_state == S_C_TOP) ? r_r : r_prod;
    assign w_c = 8'd1;
`else
    assign w_b = r_r;
    assign w_c = (r_state == S_C_TOP) ? 8'd1 : r_old;
`endif

    byte_mul_sub #(
        .FIELD (FIELD)
    ) u_mul_sub (
        .i_a (r_prev),
        .i_b (w_b),
        .i_c (w_c),
        .o_y (w_ms)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_j     <= '0;
            r_r     <= '0;
            r_prev  <= '0;
            r_old   <= '0;
`ifdef POLY_SHARED_MUL_EN
            r_prod  <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_start) r_k <= '0;
                S_R_LAT: begin
                    r_r    <= i_root;
                    r_prev <= '0;
                    r_j    <= '0;
                end
                S_C_MUL: r_old <= i_q;
`ifdef POLY_SHARED_MUL_EN
                S_C_MWAIT: if (i_done_mul_gf8) r_prod <= i_out_mul_gf8;
`endif
                S_C_WR: begin
                    r_prev <= r_old;
                    r_j    <= r_j + AW'(1);
                end
                S_C_TOP: if (r_k != K_LAST) r_k <= r_k + AW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        o_root_addr = r_k;
        o_q_addr    = r_j;
        o_q_wr_en   = 1'b0;
        o_q_data    = '0;
        o_busy      = (r_state != S_IDLE);
        o_done      = 1'b0;
`ifdef POLY_SHARED_MUL_EN
        o_start_mul_gf8 = 1'b0;
        o_in_1_mul_gf8  = '0;
        o_in_2_mul_gf8  = '0;
`endif
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_R_RD;
            S_R_RD:  w_next = S_R_LAT;
            S_R_LAT: w_next = (r_k == '0) ? S_C_TOP : S_C_RD;
            S_C_RD:  w_next = S_C_MUL;
`ifdef POLY_SHARED_MUL_EN
            S_C_MUL: begin
                o_start_mul_gf8 = 1'b1;
                o_in_1_mul_gf8  = r_r;
                o_in_2_mul_gf8  = i_q;
                w_next          = S_C_MWAIT;
            end
            S_C_MWAIT: if (i_done_mul_gf8) w_next = S_C_WR;
`else
            S_C_MUL: w_next = S_C_WR;
`endif
            S_C_WR: begin
                o_q_wr_en = 1'b1;
                o_q_data  = w_ms;
                w_next    = (r_j == r_k - AW'(1)) ? S_C_TOP : S_C_RD;
            end
            S_C_TOP: begin
                o_q_wr_en = 1'b1;
                o_q_addr  = r_k;
                o_q_data  = w_ms;
                w_next    = (r_k == K_LAST) ? S_DONE : S_R_RD;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_poly_from_roots.sv
// Self-checking bench: three poly_from_roots instances (P251 W=2, GF256 W=2, P251 W=3) with memory models.
module tb_poly_from_roots;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st   [3];
    logic       done [3];
    logic       busy [3];
    logic       wr   [3];
    logic [7:0] qd   [3];
    logic [7:0] rr   [3];
    logic [7:0] rq   [3];
    logic [0:0] ra0, qa0, ra1, qa1;
    logic [1:0] ra2, qa2;

    logic [7:0] rm [3][8];
    logic [7:0] qm [3][8];
    logic [15:0] wlog [$];
    int ndone [3];
    int exp_q [8];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    poly_from_roots #(.FIELD("P251"), .W(2)) u_p2 (
        .i_clk(clk), .i_rst(rst_n), .i_start(st[0]), .o_root_addr(ra0), .i_root(rr[0]),
        .o_q_addr(qa0), .o_q_wr_en(wr[0]), .o_q_data(qd[0]), .i_q(rq[0]),
        .o_busy(busy[0]), .o_done(done[0]));

    poly_from_roots #(.FIELD("GF256"), .W(2)) u_g2 (
        .i_clk(clk), .i_rst(rst_n), .i_start(st[1]), .o_root_addr(ra1), .i_root(rr[1]),
        .o_q_addr(qa1), .o_q_wr_en(wr[1]), .o_q_data(qd[1]), .i_q(rq[1]),
        .o_busy(busy[1]), .o_done(done[1]));

    poly_from_roots #(.FIELD("P251"), .W(3)) u_p3 (
        .i_clk(clk), .i_rst(rst_n), .i_start(st[2]), .o_root_addr(ra2), .i_root(rr[2]),
        .o_q_addr(qa2), .o_q_wr_en(wr[2]), .o_q_data(qd[2]), .i_q(rq[2]),
        .o_busy(busy[2]), .o_done(done[2]));

    // Single-port memories with one-cycle read latency.
    always @(posedge clk) begin
        rr[0] <= rm[0][ra0];
        rq[0] <= qm[0][qa0];
        if (wr[0]) begin
            qm[0][qa0] <= qd[0];
            wlog.push_back({8'(qa0), qd[0]});
        end
        rr[1] <= rm[1][ra1];
        rq[1] <= qm[1][qa1];
        if (wr[1]) qm[1][qa1] <= qd[1];
        rr[2] <= rm[2][ra2];
        rq[2] <= qm[2][qa2];
        if (wr[2]) qm[2][qa2] <= qd[2];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (done[i] === 1'b1) ndone[i]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int gmul(input int a_in, input int b_in);
        int a = a_in;
        int b = b_in;
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b & 1) != 0) p = p ^ a;
            b = b >> 1;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 283;
        end
        return p;
    endfunction

    function automatic int fmul(input int inst, input int a, input int b);
        return (inst == 1) ? gmul(a, b) : (a * b) % 251;
    endfunction

    function automatic int fadd(input int inst, input int a, input int b);
        return (inst == 1) ? (a ^ b) : (a + b) % 251;
    endfunction

    function automatic int fneg(input int inst, input int a);
        return (inst == 1) ? a : (251 - a) % 251;
    endfunction

    // Reference: expand prod (X - r_k) by full polynomial multiplication.
    task automatic model(input int inst, input int w);
        int c [9];
        int nc [9];
        for (int j = 0; j < 9; j++) c[j] = 0;
        c[0] = 1;
        for (int k = 0; k < w; k++) begin
            for (int j = 0; j < 9; j++) nc[j] = 0;
            for (int j = 0; j <= k; j++) begin
                nc[j + 1] = fadd(inst, nc[j + 1], c[j]);
                nc[j]     = fadd(inst, nc[j], fneg(inst, fmul(inst, int'(rm[inst][k]), c[j])));
            end
            c = nc;
        end
        for (int j = 0; j < 8; j++) exp_q[j] = (j < w) ? c[j] : 0;
    endtask

    task automatic run(input int inst, input int w, input bit extra_start);
        int cyc = 0;
        bit seen = 0;
        int nd0;
        model(inst, w);
        nd0 = ndone[inst];
        @(negedge clk);
        st[inst] = 1'b1;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            st[inst] = extra_start && (cyc == 5);
            if (cyc == 1) check($sformatf("busy_after_start_i%0d", inst), 32'(busy[inst]), 1);
            if (done[inst] === 1'b1) seen = 1;
        end
        st[inst] = 1'b0;
        check($sformatf("done_seen_i%0d", inst), 32'(seen), 1);
        check($sformatf("done_cycle_i%0d", inst), cyc, 3 * w * (w + 1) / 2 + 1);
        repeat (4) @(negedge clk);
        check($sformatf("done_count_i%0d", inst), ndone[inst] - nd0, 1);
        check($sformatf("idle_busy_i%0d", inst), 32'(busy[inst]), 0);
        for (int j = 0; j < w; j++)
            check($sformatf("q%0d_i%0d", j, inst), 32'(qm[inst][j]), exp_q[j]);
    endtask

    initial begin
        int nw;
        int cyc;
        int nd0;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy_i%0d", i), 32'(busy[i]), 0);
            check($sformatf("rst_done_i%0d", i), 32'(done[i]), 0);
            check($sformatf("rst_wr_i%0d", i), 32'(wr[i]), 0);
            check($sformatf("rst_qd_i%0d", i), 32'(qd[i]), 0);
        end
        check("rst_addr_i0", 32'({ra0, qa0}), 0);
        check("rst_addr_i2", 32'({ra2, qa2}), 0);
        rst_n = 1'b1;

        // P251 roots {1,2}: intermediate q0=250, final q0=2, q1=248.
        rm[0][0] = 8'd1; rm[0][1] = 8'd2;
        run(0, 2, 1'b0);
        check("wlog_len", wlog.size(), 3);
        check("wlog_0", 32'(wlog[0]), 32'h00FA);
        check("wlog_1", 32'(wlog[1]), 32'h0002);
        check("wlog_2", 32'(wlog[2]), 32'h01F8);

        // GF256 roots {1,2}: (X+1)(X+2) = X^2 + 3X + 2.
        rm[1][0] = 8'h01; rm[1][1] = 8'h02;
        run(1, 2, 1'b0);
        check("gf_q0_const", 32'(qm[1][0]), 2);
        check("gf_q1_const", 32'(qm[1][1]), 3);

        // Q = X^3.
        for (int i = 0; i < 3; i++) rm[2][i] = 8'd0;
        run(2, 3, 1'b0);

        // (X+1)^3 = X^3 + 3X^2 + 3X + 1.
        for (int i = 0; i < 3; i++) rm[2][i] = 8'd250;
        run(2, 3, 1'b0);
        check("cube_q0", 32'(qm[2][0]), 1);
        check("cube_q1", 32'(qm[2][1]), 3);
        check("cube_q2", 32'(qm[2][2]), 3);

        // Reset during the first C_WR (second write of the run).
        for (int i = 0; i < 3; i++) rm[2][i] = 8'($urandom_range(0, 250));
        @(negedge clk);
        st[2] = 1'b1;
        nw = 0;
        cyc = 0;
        while (nw < 2 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            st[2] = 1'b0;
            if (wr[2] === 1'b1) nw++;
        end
        check("rst_reach_cwr", nw, 2);
        nd0 = ndone[2];
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_wr", 32'(wr[2]), 0);
        check("midrst_busy", 32'(busy[2]), 0);
        check("midrst_addr", 32'(qa2), 0);
        repeat (30) @(negedge clk);
        check("midrst_no_done", ndone[2] - nd0, 0);
        run(2, 3, 1'b0);

        // Second start mid-run must be ignored.
        for (int i = 0; i < 3; i++) rm[2][i] = 8'($urandom_range(0, 250));
        run(2, 3, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 2; i++) rm[0][i] = 8'($urandom_range(0, 250));
            run(0, 2, 1'b0);
            for (int i = 0; i < 2; i++) rm[1][i] = 8'($urandom_range(0, 255));
            run(1, 2, 1'b0);
            for (int i = 0; i < 3; i++) rm[2][i] = 8'($urandom_range(0, 250));
            run(2, 3, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
